// File: rtl/pl_ctrl_stage_if.sv
// ID/EX control boundary bundle: instruction and branch-condition inputs in,
// hazard controls and the registered EX control word out.
interface pl_ctrl_stage_if;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_zero;

  logic        stall_fd;
  logic        flush_fd;
  logic [4:0]  npc_op;

  logic        ex_valid;
  logic        ex_regwrite;
  logic        ex_memwrite;
  logic        ex_memread;
  logic        ex_alusrc;
  logic [5:0]  ex_extop;
  logic [4:0]  ex_aluop;
  logic [1:0]  ex_wdsel;
  logic [2:0]  ex_dmtype;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic        ex_illegal;
  logic        mul_busy;

  modport master (
    output id_instr, id_valid, ex_zero,
    input  stall_fd, flush_fd, npc_op,
    input  ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_alusrc,
    input  ex_extop, ex_aluop, ex_wdsel, ex_dmtype, ex_rd, ex_rs1, ex_rs2,
    input  ex_branch, ex_jal, ex_jalr, ex_illegal, mul_busy
  );

  modport slave (
    input  id_instr, id_valid, ex_zero,
    output stall_fd, flush_fd, npc_op,
    output ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_alusrc,
    output ex_extop, ex_aluop, ex_wdsel, ex_dmtype, ex_rd, ex_rs1, ex_rs2,
    output ex_branch, ex_jal, ex_jalr, ex_illegal, mul_busy
  );
endinterface

// File: rtl/pl_ctrl_stage.sv
// Pipelined RV32I(+MUL) control stage: decodes ID, registers the ID/EX control
// word, and produces load-use stall, branch/jump flush, NPC select and MUL hold.
module pl_ctrl_stage #(
  parameter bit          EN_M       = 1'b1,
  parameter int unsigned MUL_LAT    = 3,
  parameter bit          EN_BYTE_LS = 1'b1
) (
  input logic           clk,
  input logic           reset,
  pl_ctrl_stage_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_BNE   = 5'b00101;
  localparam logic [4:0] ALU_BLT   = 5'b00110;
  localparam logic [4:0] ALU_BGE   = 5'b00111;
  localparam logic [4:0] ALU_BLTU  = 5'b01000;
  localparam logic [4:0] ALU_BGEU  = 5'b01001;
  localparam logic [4:0] ALU_SLT   = 5'b01010;
  localparam logic [4:0] ALU_SLTU  = 5'b01011;
  localparam logic [4:0] ALU_XOR   = 5'b01100;
  localparam logic [4:0] ALU_OR    = 5'b01101;
  localparam logic [4:0] ALU_AND   = 5'b01110;
  localparam logic [4:0] ALU_SLL   = 5'b01111;
  localparam logic [4:0] ALU_SRL   = 5'b10000;
  localparam logic [4:0] ALU_SRA   = 5'b10001;
  localparam logic [4:0] ALU_MUL   = 5'b10010;

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam bit         MUL_MULTI = (MUL_LAT > 1);
  localparam logic [3:0] CNT_INIT  = MUL_MULTI ? 4'(MUL_LAT - 2) : 4'd0;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       alusrc;
    logic [5:0] extop;
    logic [4:0] aluop;
    logic [1:0] wdsel;
    logic [2:0] dmtype;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;

  assign opcode = bus.id_instr[6:0];
  assign f3     = bus.id_instr[14:12];
  assign f7     = bus.id_instr[31:25];
  assign id_rs1 = bus.id_instr[19:15];
  assign id_rs2 = bus.id_instr[24:20];

  ctrl_t dec;
  ctrl_t ex_q;
  ctrl_t ex_d;
  logic  legal;

  // NOTE: every signal gets a default at the top so no path leaves it unassigned
  // and a latch is never inferred.
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    dec.rd  = bus.id_instr[11:7];
    dec.rs1 = id_rs1;
    dec.rs2 = id_rs2;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
        dec.extop = EXT_U; dec.aluop = ALU_LUI;
      end
      OPC_AUIPC: begin
        legal = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
        dec.extop = EXT_U; dec.aluop = ALU_AUIPC;
      end
      OPC_JAL: begin
        legal = 1'b1; dec.regwrite = 1'b1; dec.extop = EXT_J;
        dec.jal = 1'b1; dec.wdsel = WD_PC;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); dec.regwrite = 1'b1; dec.alusrc = 1'b1;
        dec.extop = EXT_I; dec.aluop = ALU_ADD; dec.jalr = 1'b1; dec.wdsel = WD_PC;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1; dec.extop = EXT_B; legal = 1'b1;
        case (f3)
          3'b000:  dec.aluop = ALU_SUB;
          3'b001:  dec.aluop = ALU_BNE;
          3'b100:  dec.aluop = ALU_BLT;
          3'b101:  dec.aluop = ALU_BGE;
          3'b110:  dec.aluop = ALU_BLTU;
          3'b111:  dec.aluop = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.regwrite = 1'b1; dec.memread = 1'b1; dec.alusrc = 1'b1;
        dec.extop = EXT_I; dec.aluop = ALU_ADD; dec.wdsel = WD_MEM;
        case (f3)
          3'b010:  begin legal = 1'b1;       dec.dmtype = DM_WORD;   end
          3'b000:  begin legal = EN_BYTE_LS; dec.dmtype = DM_BYTE;   end
          3'b001:  begin legal = EN_BYTE_LS; dec.dmtype = DM_HALF;   end
          3'b100:  begin legal = EN_BYTE_LS; dec.dmtype = DM_BYTE_U; end
          3'b101:  begin legal = EN_BYTE_LS; dec.dmtype = DM_HALF_U; end
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec.memwrite = 1'b1; dec.alusrc = 1'b1;
        dec.extop = EXT_S; dec.aluop = ALU_ADD;
        case (f3)
          3'b010:  begin legal = 1'b1;       dec.dmtype = DM_WORD; end
          3'b000:  begin legal = EN_BYTE_LS; dec.dmtype = DM_BYTE; end
          3'b001:  begin legal = EN_BYTE_LS; dec.dmtype = DM_HALF; end
          default: legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.extop = EXT_I; legal = 1'b1;
        case (f3)
          3'b000: dec.aluop = ALU_ADD;
          3'b010: dec.aluop = ALU_SLT;
          3'b011: dec.aluop = ALU_SLTU;
          3'b100: dec.aluop = ALU_XOR;
          3'b110: dec.aluop = ALU_OR;
          3'b111: dec.aluop = ALU_AND;
          3'b001: begin
            dec.extop = EXT_SHAMT; dec.aluop = ALU_SLL; legal = (f7 == 7'b0000000);
          end
          default: begin // 3'b101: srli / srai share funct3, split on funct7
            dec.extop = EXT_SHAMT;
            dec.aluop = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            legal     = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          end
        endcase
      end
      OPC_OP: begin
        dec.regwrite = 1'b1;
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          case (f3)
            3'b000:  dec.aluop = ALU_ADD;
            3'b001:  dec.aluop = ALU_SLL;
            3'b010:  dec.aluop = ALU_SLT;
            3'b011:  dec.aluop = ALU_SLTU;
            3'b100:  dec.aluop = ALU_XOR;
            3'b101:  dec.aluop = ALU_SRL;
            3'b110:  dec.aluop = ALU_OR;
            default: dec.aluop = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      begin legal = 1'b1; dec.aluop = ALU_SUB; end
          else if (f3 == 3'b101) begin legal = 1'b1; dec.aluop = ALU_SRA; end
        end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
          legal = EN_M; dec.aluop = ALU_MUL;
        end
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings still occupy EX so a trap can be raised there.
    if (!legal) begin
      dec.regwrite = 1'b0; dec.memwrite = 1'b0; dec.memread = 1'b0;
      dec.alusrc   = 1'b0; dec.extop    = '0;   dec.aluop   = ALU_NOP;
      dec.wdsel    = WD_ALU; dec.dmtype = DM_WORD;
      dec.branch   = 1'b0; dec.jal      = 1'b0; dec.jalr    = 1'b0;
      dec.illegal  = 1'b1;
    end
    dec.valid = 1'b1;
    if (!bus.id_valid) dec = '0;
  end

  logic rs1_used;
  logic rs2_used;
  assign rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

  logic take_br;
  logic flush;
  logic load_use;
  logic mul_stall;
  logic mul_entry;
  logic [0:0] state;
  logic [3:0] cnt;

  assign take_br = ex_q.valid & ex_q.branch & bus.ex_zero;
  assign flush   = take_br | ex_q.jal | ex_q.jalr;

  assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & bus.id_valid &
                    ((rs1_used & (ex_q.rd == id_rs1)) | (rs2_used & (ex_q.rd == id_rs2)));

  // The exit cycle (cnt==0) is not stalled so the next instruction loads as the
  // MUL leaves, giving exactly MUL_LAT cycles of EX occupancy.
  assign mul_entry = ex_q.valid & (ex_q.aluop == ALU_MUL) & MUL_MULTI;
  assign mul_stall = ((state == S_IDLE) & mul_entry) | ((state == S_BUSY) & (cnt != 4'd0));

  always_comb begin
    ex_d = ex_q;
    if (flush)          ex_d = '0;
    else if (mul_stall) ex_d = ex_q;
    else if (load_use)  ex_d = '0;
    else                ex_d = dec;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mul_entry) begin
            state <= S_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        default: begin
          if (cnt == 4'd0) state <= S_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
      endcase
    end
  end

  assign bus.stall_fd    = mul_stall | (load_use & ~flush);
  assign bus.flush_fd    = flush;
  assign bus.npc_op      = {2'b00, ex_q.jalr, ex_q.jal, take_br};
  assign bus.mul_busy    = (state == S_BUSY);

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_extop    = ex_q.extop;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_wdsel    = ex_q.wdsel;
  assign bus.ex_dmtype   = ex_q.dmtype;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_jal      = ex_q.jal;
  assign bus.ex_jalr     = ex_q.jalr;
  assign bus.ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_pl_ctrl_stage.sv
// Directed bench for pl_ctrl_stage: three parameter variants share stimulus;
// the default variant's EX control word is checked against a scoreboard.
module tb_pl_ctrl_stage;

  logic clk;
  logic reset;

  pl_ctrl_stage_if if0 ();
  pl_ctrl_stage_if if1 ();
  pl_ctrl_stage_if if2 ();

  pl_ctrl_stage #(.EN_M(1'b1), .MUL_LAT(3), .EN_BYTE_LS(1'b1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  pl_ctrl_stage #(.EN_M(1'b1), .MUL_LAT(1), .EN_BYTE_LS(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1));
  pl_ctrl_stage #(.EN_M(1'b0), .MUL_LAT(3), .EN_BYTE_LS(1'b1)) u2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_LW5    = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] I_LW0    = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD65  = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] I_ADD60  = 32'h0020_0333; // add  x6,x0,x2
  localparam logic [31:0] I_ADD4   = 32'h0020_8233; // add  x4,x1,x2
  localparam logic [31:0] I_BEQ    = 32'h0020_8463; // beq  x1,x2,8
  localparam logic [31:0] I_MUL    = 32'h0220_81B3; // mul  x3,x1,x2
  localparam logic [31:0] I_LBU    = 32'h0000_C383; // lbu  x7,0(x1)
  localparam logic [31:0] I_SH     = 32'h0020_9023; // sh   x2,0(x1)
  localparam logic [31:0] I_JALR   = 32'h0002_80E7; // jalr x1,0(x5)
  localparam logic [31:0] I_BAD    = 32'hFFFF_FFFF;

  localparam logic [4:0] A_ADD = 5'b00011;
  localparam logic [4:0] A_SUB = 5'b00100;
  localparam logic [4:0] A_MUL = 5'b10010;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       illegal;
    logic [4:0] aluop;
    logic [5:0] extop;
    logic [1:0] wdsel;
    logic [2:0] dmtype;
    logic [4:0] rd;
    logic [4:0] rs1;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic exp_t mk(input logic rw, input logic mw, input logic mr, input logic ill,
                              input logic [4:0] alu, input logic [5:0] ext, input logic [1:0] wd,
                              input logic [2:0] dm, input logic [4:0] rd, input logic [4:0] rs1);
    exp_t e;
    e.valid = 1'b1; e.regwrite = rw; e.memwrite = mw; e.memread = mr; e.illegal = ill;
    e.aluop = alu; e.extop = ext; e.wdsel = wd; e.dmtype = dm; e.rd = rd; e.rs1 = rs1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic v, input logic z);
    if0.id_instr = instr; if0.id_valid = v; if0.ex_zero = z;
    if1.id_instr = instr; if1.id_valid = v; if1.ex_zero = z;
    if2.id_instr = instr; if2.id_valid = v; if2.ex_zero = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".valid"},    32'(if0.ex_valid),    32'(e.valid));
      check({tag, ".regwrite"}, 32'(if0.ex_regwrite), 32'(e.regwrite));
      check({tag, ".memwrite"}, 32'(if0.ex_memwrite), 32'(e.memwrite));
      check({tag, ".memread"},  32'(if0.ex_memread),  32'(e.memread));
      check({tag, ".illegal"},  32'(if0.ex_illegal),  32'(e.illegal));
      check({tag, ".aluop"},    32'(if0.ex_aluop),    32'(e.aluop));
      check({tag, ".extop"},    32'(if0.ex_extop),    32'(e.extop));
      check({tag, ".wdsel"},    32'(if0.ex_wdsel),    32'(e.wdsel));
      check({tag, ".dmtype"},   32'(if0.ex_dmtype),   32'(e.dmtype));
      check({tag, ".rd"},       32'(if0.ex_rd),       32'(e.rd));
      check({tag, ".rs1"},      32'(if0.ex_rs1),      32'(e.rs1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t bubble;
    bubble = '0;

    // Reset held with a live instruction in ID.
    reset = 1'b1;
    drive(I_ADDI, 1'b1, 1'b0);
    tick(); tick();
    check("rst.ex_valid",  32'(if0.ex_valid),    32'd0);
    check("rst.regwrite",  32'(if0.ex_regwrite), 32'd0);
    check("rst.aluop",     32'(if0.ex_aluop),    32'd0);
    check("rst.extop",     32'(if0.ex_extop),    32'd0);
    check("rst.rd",        32'(if0.ex_rd),       32'd0);
    check("rst.mul_busy",  32'(if0.mul_busy),    32'd0);
    check("rst.stall",     32'(if0.stall_fd),    32'd0);
    check("rst.flush",     32'(if0.flush_fd),    32'd0);
    check("rst.npc",       32'(if0.npc_op),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(mk(1, 0, 0, 0, A_ADD, 6'b010000, 2'b00, 3'b000, 5'd1, 5'd0));
    tick(); sb_check("addi");

    // Load-use: lw x5 then add x6,x5,x2.
    drive(I_LW5, 1'b1, 1'b0);
    sb_q.push_back(mk(1, 0, 1, 0, A_ADD, 6'b010000, 2'b01, 3'b000, 5'd5, 5'd1));
    tick(); sb_check("lw_x5");
    drive(I_ADD65, 1'b1, 1'b0); #1;
    check("lu.stall", 32'(if0.stall_fd), 32'd1);
    check("lu.flush", 32'(if0.flush_fd), 32'd0);
    sb_q.push_back(bubble);
    tick(); sb_check("lu_bubble");
    check("lu.stall_released", 32'(if0.stall_fd), 32'd0);
    sb_q.push_back(mk(1, 0, 0, 0, A_ADD, 6'b000000, 2'b00, 3'b000, 5'd6, 5'd5));
    tick(); sb_check("lu_add");

    // Same pair with rd = x0: no hazard.
    drive(I_LW0, 1'b1, 1'b0);
    sb_q.push_back(mk(1, 0, 1, 0, A_ADD, 6'b010000, 2'b01, 3'b000, 5'd0, 5'd1));
    tick(); sb_check("lw_x0");
    drive(I_ADD60, 1'b1, 1'b0); #1;
    check("lu_x0.stall", 32'(if0.stall_fd), 32'd0);
    sb_q.push_back(mk(1, 0, 0, 0, A_ADD, 6'b000000, 2'b00, 3'b000, 5'd6, 5'd0));
    tick(); sb_check("add_x0");

    // Branch taken.
    drive(I_BEQ, 1'b1, 1'b0);
    sb_q.push_back(mk(0, 0, 0, 0, A_SUB, 6'b000100, 2'b00, 3'b000, 5'd8, 5'd1));
    tick(); sb_check("beq_t");
    drive(I_ADD4, 1'b1, 1'b1); #1;
    check("br_t.npc",   32'(if0.npc_op),   32'b00001);
    check("br_t.flush", 32'(if0.flush_fd), 32'd1);
    check("br_t.stall", 32'(if0.stall_fd), 32'd0);
    sb_q.push_back(bubble);
    tick(); sb_check("br_t_bubble");
    check("br_t.flush_one_cycle", 32'(if0.flush_fd), 32'd0);
    check("br_t.npc_after",       32'(if0.npc_op),   32'd0);

    // Branch not taken.
    drive(I_BEQ, 1'b1, 1'b0);
    sb_q.push_back(mk(0, 0, 0, 0, A_SUB, 6'b000100, 2'b00, 3'b000, 5'd8, 5'd1));
    tick(); sb_check("beq_nt");
    drive(I_ADD4, 1'b1, 1'b0); #1;
    check("br_nt.npc",   32'(if0.npc_op),   32'd0);
    check("br_nt.flush", 32'(if0.flush_fd), 32'd0);
    sb_q.push_back(mk(1, 0, 0, 0, A_ADD, 6'b000000, 2'b00, 3'b000, 5'd4, 5'd1));
    tick(); sb_check("br_nt_add");

    // MUL latency: u0 MUL_LAT=3, u1 MUL_LAT=1, u2 has no M extension.
    drive(I_MUL, 1'b1, 1'b0);
    sb_q.push_back(mk(1, 0, 0, 0, A_MUL, 6'b000000, 2'b00, 3'b000, 5'd3, 5'd1));
    tick(); sb_check("mul");
    check("nom.illegal",  32'(if2.ex_illegal),  32'd1);
    check("nom.regwrite", 32'(if2.ex_regwrite), 32'd0);
    check("nom.valid",    32'(if2.ex_valid),    32'd1);
    drive(I_ADD4, 1'b1, 1'b0); #1;
    check("mul.c0.busy",  32'(if0.mul_busy), 32'd0);
    check("mul.c0.stall", 32'(if0.stall_fd), 32'd1);
    check("lat1.stall",   32'(if1.stall_fd), 32'd0);
    check("nom.stall",    32'(if2.stall_fd), 32'd0);
    sb_q.push_back(mk(1, 0, 0, 0, A_MUL, 6'b000000, 2'b00, 3'b000, 5'd3, 5'd1));
    tick(); sb_check("mul_hold1");
    check("lat1.add_rd",  32'(if1.ex_rd),    32'd4);
    check("lat1.busy",    32'(if1.mul_busy), 32'd0);
    check("mul.c1.busy",  32'(if0.mul_busy), 32'd1);
    check("mul.c1.stall", 32'(if0.stall_fd), 32'd1);
    sb_q.push_back(mk(1, 0, 0, 0, A_MUL, 6'b000000, 2'b00, 3'b000, 5'd3, 5'd1));
    tick(); sb_check("mul_hold2");
    check("mul.c2.busy",  32'(if0.mul_busy), 32'd1);
    check("mul.c2.stall", 32'(if0.stall_fd), 32'd0);
    sb_q.push_back(mk(1, 0, 0, 0, A_ADD, 6'b000000, 2'b00, 3'b000, 5'd4, 5'd1));
    tick(); sb_check("add_after_mul");
    check("mul.c3.busy",  32'(if0.mul_busy), 32'd0);
    check("mul.c3.stall", 32'(if0.stall_fd), 32'd0);

    // Byte/half loads and stores; u1 has them disabled.
    drive(I_LBU, 1'b1, 1'b0);
    sb_q.push_back(mk(1, 0, 1, 0, A_ADD, 6'b010000, 2'b01, 3'b100, 5'd7, 5'd1));
    tick(); sb_check("lbu");
    check("nobyte.lbu.illegal",  32'(if1.ex_illegal),  32'd1);
    check("nobyte.lbu.memread",  32'(if1.ex_memread),  32'd0);
    check("nobyte.lbu.regwrite", 32'(if1.ex_regwrite), 32'd0);
    drive(I_SH, 1'b1, 1'b0);
    sb_q.push_back(mk(0, 1, 0, 0, A_ADD, 6'b001000, 2'b00, 3'b001, 5'd0, 5'd1));
    tick(); sb_check("sh");
    check("nobyte.sh.illegal",  32'(if1.ex_illegal),  32'd1);
    check("nobyte.sh.memwrite", 32'(if1.ex_memwrite), 32'd0);

    // JALR in EX wins over anything in ID.
    drive(I_JALR, 1'b1, 1'b0);
    sb_q.push_back(mk(1, 0, 0, 0, A_ADD, 6'b010000, 2'b10, 3'b000, 5'd1, 5'd5));
    tick(); sb_check("jalr");
    drive(I_ADD65, 1'b1, 1'b0); #1;
    check("jalr.flush", 32'(if0.flush_fd), 32'd1);
    check("jalr.stall", 32'(if0.stall_fd), 32'd0);
    check("jalr.npc",   32'(if0.npc_op),   32'b00100);
    check("jalr.wdsel", 32'(if0.ex_wdsel), 32'b10);
    sb_q.push_back(bubble);
    tick(); sb_check("jalr_bubble");

    // id_valid=0 bubble, then an undecodable word.
    drive(I_ADDI, 1'b0, 1'b0);
    sb_q.push_back(bubble);
    tick(); sb_check("idle_bubble");
    drive(I_BAD, 1'b1, 1'b0);
    sb_q.push_back(mk(0, 0, 0, 1, 5'd0, 6'd0, 2'b00, 3'b000, 5'd31, 5'd31));
    tick(); sb_check("illegal");

    // Reset while the MUL sequencer is BUSY.
    drive(I_MUL, 1'b1, 1'b0);
    sb_q.push_back(mk(1, 0, 0, 0, A_MUL, 6'b000000, 2'b00, 3'b000, 5'd3, 5'd1));
    tick(); sb_check("mul2");
    drive(I_ADDI, 1'b1, 1'b0);
    tick();
    check("rstbusy.pre_busy", 32'(if0.mul_busy), 32'd1);
    reset = 1'b1; #1;
    check("rstbusy.busy",     32'(if0.mul_busy), 32'd0);
    check("rstbusy.ex_valid", 32'(if0.ex_valid), 32'd0);
    check("rstbusy.stall",    32'(if0.stall_fd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(mk(1, 0, 0, 0, A_ADD, 6'b010000, 2'b00, 3'b000, 5'd1, 5'd0));
    tick(); sb_check("addi_after_rst");
    check("rstbusy.stall_after", 32'(if0.stall_fd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
